// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared BCD widths, limits and nibble decode/validity helpers.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int              BCD_W   = 4;
    localparam int              DEC_W   = 10;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    function automatic logic [DEC_W-1:0] bcd_to_onehot(input logic [BCD_W-1:0] nib);
        return (nib <= BCD_MAX) ? (DEC_W'(1) << nib) : '0;
    endfunction

    function automatic logic bcd_valid(input logic [BCD_W-1:0] nib);
        return (nib <= BCD_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_cell.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_cell
// Brief    : One BCD digit register with clear, load and ripple carry.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_val_i,
    input  logic             cin_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             cout_o
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (load_i) begin
            digit_d = load_val_i;
        end else if (cin_i) begin
            digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + BCD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign cout_o  = cin_i & (digit_q == BCD_MAX);

endmodule
`default_nettype wire

// File: rtl/bcd_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_counter
// Brief    : Multi-digit BCD counter with scanned one-hot decimal output.
//            Optional macro BCD_SCAN_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_scan_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_data,
    input  logic                    inc,
    output logic [BCD_W*DIGITS-1:0] cnt_val,
    output logic                    carry_out,
    output logic                    load_err,
    output logic [DIGITS-1:0]       dig_sel,
    output logic [DEC_W-1:0]        dec_out
);

    localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                 w_load_ok;
    logic                 w_do_load;
    logic                 w_do_err;
    logic [DIGITS:0]      w_carry;
    logic [BCD_W-1:0]     w_digit [DIGITS];

    always_comb begin
        w_load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_load_ok = w_load_ok & bcd_valid(load_data[i*BCD_W +: BCD_W]);
        end
    end

    // Any load request, valid or not, masks a same-cycle increment.
    assign w_do_load  = load & ~clr & w_load_ok;
    assign w_do_err   = load & ~clr & ~w_load_ok;
    assign w_carry[0] = inc & ~clr & ~load;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_cell u_cell (
                .clk        (clk),
                .rst        (rst),
                .clr_i      (clr),
                .load_i     (w_do_load),
                .load_val_i (load_data[g*BCD_W +: BCD_W]),
                .cin_i      (w_carry[g]),
                .digit_o    (w_digit[g]),
                .cout_o     (w_carry[g+1])
            );
            assign cnt_val[g*BCD_W +: BCD_W] = w_digit[g];
        end
    endgenerate

    logic carry_q;
    logic load_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            carry_q    <= w_carry[DIGITS];
            load_err_q <= w_do_err;
        end
    end

    logic [c_PRE_W-1:0] pre_q;
    logic [c_PRE_W-1:0] pre_d;
    logic [c_IDX_W-1:0] idx_q;
    logic [c_IDX_W-1:0] idx_d;
    logic               w_slot_end;

    assign w_slot_end = (pre_q == c_PRE_W'(SCAN_DIV - 1));

    always_comb begin
        pre_d = w_slot_end ? '0 : pre_q + c_PRE_W'(1);
        idx_d = idx_q;
        if (w_slot_end) begin
            idx_d = (idx_q == c_IDX_W'(DIGITS - 1)) ? '0 : idx_q + c_IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
        end
    end

    logic [BCD_W-1:0] w_sel_nib;
    logic             w_blank;

    always_comb begin
        w_sel_nib = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == c_IDX_W'(i)) begin
                w_sel_nib = w_digit[i];
            end
        end
    end

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a slot blanks while everything at or above it is zero.
    always_comb begin : p_blank
        logic v_upper_zero;
        v_upper_zero = 1'b1;
        w_blank      = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            v_upper_zero = v_upper_zero & (w_digit[i] == '0);
            if (idx_q == c_IDX_W'(i)) begin
                w_blank = v_upper_zero;
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    logic [DIGITS-1:0] dig_sel_q;
    logic [DEC_W-1:0]  dec_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_sel_q <= DIGITS'(1);
            dec_out_q <= DEC_W'(1);
        end else begin
            dig_sel_q <= DIGITS'(1) << idx_q;
            dec_out_q <= w_blank ? '0 : bcd_to_onehot(w_sel_nib);
        end
    end

    assign carry_out = carry_q;
    assign load_err  = load_err_q;
    assign dig_sel   = dig_sel_q;
    assign dec_out   = dec_out_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_scan_counter
// Brief    : Scoreboard bench for bcd_scan_counter (DIGITS=4, SCAN_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_counter;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        load;
    logic        inc;
    logic [15:0] load_data;
    logic [15:0] cnt_val;
    logic        carry_out;
    logic        load_err;
    logic [3:0]  dig_sel;
    logic [9:0]  dec_out;

    int total = 0;
    int bad   = 0;

    logic [17:0] exp_q [$];
    logic [17:0] got_q [$];

    bcd_scan_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .load      (load),
        .load_data (load_data),
        .inc       (inc),
        .cnt_val   (cnt_val),
        .carry_out (carry_out),
        .load_err  (load_err),
        .dig_sel   (dig_sel),
        .dec_out   (dec_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One counter cycle: push the expectation, clock, capture the result.
    task automatic drive(input logic c, input logic l, input logic [15:0] d, input logic i,
                         input logic [15:0] ecnt, input logic ecy, input logic eerr);
        clr = c; load = l; load_data = d; inc = i;
        exp_q.push_back({ecnt, ecy, eerr});
        tick();
        got_q.push_back({cnt_val, carry_out, load_err});
        clr = 1'b0; load = 1'b0; inc = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int v;
        v = n;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            r[j*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1; clr = 1'b0; load = 1'b0; inc = 1'b0; load_data = '0;
        tick();
        tick();
        total += 5;
        if (cnt_val !== 16'h0000) begin bad++; $display("FAIL reset_cnt got=%h exp=0000", cnt_val); end
        if (carry_out !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", carry_out); end
        if (load_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", load_err); end
        if (dig_sel !== 4'b0001) begin bad++; $display("FAIL reset_sel got=%b exp=0001", dig_sel); end
        if (dec_out !== 10'b0000000001) begin bad++; $display("FAIL reset_dec got=%b exp=0000000001", dec_out); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid;
        int  n;
        logic [17:0] e, g;
        drive(1'b0, 1'b1, 16'h0042, 1'b0, 16'h0042, 1'b0, 1'b0);
        n = 0;
        while (dig_sel !== 4'b0100 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n >= 40) begin bad++; $display("FAIL mid_wait_sel got=%b exp=0100", dig_sel); end
        #2 rst = 1'b1;
        #1;
        total += 5;
        if (cnt_val !== 16'h0000) begin bad++; $display("FAIL mid_cnt got=%h exp=0000", cnt_val); end
        if (dig_sel !== 4'b0001) begin bad++; $display("FAIL mid_sel got=%b exp=0001", dig_sel); end
        if (dec_out !== 10'b0000000001) begin bad++; $display("FAIL mid_dec got=%b exp=0000000001", dec_out); end
        if (carry_out !== 1'b0) begin bad++; $display("FAIL mid_carry got=%b exp=0", carry_out); end
        if (load_err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", load_err); end
        tick();
        rst = 1'b0;
        // In-flight carry and load_err pulses must also be killed by reset.
        drive(1'b0, 1'b1, 16'h9999, 1'b0, 16'h9999, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        total++;
        if (carry_out !== 1'b0) begin bad++; $display("FAIL mid_carry_kill got=%b exp=0", carry_out); end
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b1, 16'h00B0, 1'b0, 16'h0000, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        total++;
        if (load_err !== 1'b0) begin bad++; $display("FAIL mid_err_kill got=%b exp=0", load_err); end
        tick();
        rst = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL mid_row cnt/cy/err got=%h/%b/%b exp=%h/%b/%b", g[17:2], g[1], g[0], e[17:2], e[1], e[0]); end
        end
    endtask

    task automatic test_ripple;
        logic [17:0] e, g;
        drive(1'b0, 1'b1, 16'h0199, 1'b0, 16'h0199, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0200, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0200, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL ripple cnt/cy/err got=%h/%b/%b exp=%h/%b/%b", g[17:2], g[1], g[0], e[17:2], e[1], e[0]); end
        end
    endtask

    task automatic test_wrap;
        logic [17:0] e, g;
        drive(1'b0, 1'b1, 16'h9999, 1'b0, 16'h9999, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL wrap cnt/cy/err got=%h/%b/%b exp=%h/%b/%b", g[17:2], g[1], g[0], e[17:2], e[1], e[0]); end
        end
    endtask

    task automatic test_invalid_load;
        logic [17:0] e, g;
        drive(1'b0, 1'b1, 16'h0007, 1'b0, 16'h0007, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 16'h12A4, 1'b0, 16'h0007, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0007, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 16'hF000, 1'b1, 16'h0007, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 16'h9999, 1'b0, 16'h9999, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 16'h000A, 1'b0, 16'h9999, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL invalid_load cnt/cy/err got=%h/%b/%b exp=%h/%b/%b", g[17:2], g[1], g[0], e[17:2], e[1], e[0]); end
        end
    endtask

    task automatic test_priority;
        logic [17:0] e, g;
        drive(1'b0, 1'b1, 16'h0055, 1'b0, 16'h0055, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'h0123, 1'b1, 16'h0000, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 16'h0123, 1'b1, 16'h0123, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0124, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'h00F0, 1'b0, 16'h0000, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 16'h9999, 1'b0, 16'h9999, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL priority cnt/cy/err got=%h/%b/%b exp=%h/%b/%b", g[17:2], g[1], g[0], e[17:2], e[1], e[0]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [17:0] e, g;
        drive(1'b0, 1'b1, 16'h0995, 1'b0, 16'h0995, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b1, to_bcd(995 + k), 1'b0, 1'b0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL back_to_back cnt/cy/err got=%h/%b/%b exp=%h/%b/%b", g[17:2], g[1], g[0], e[17:2], e[1], e[0]); end
        end
    endtask

    // Scan from a fresh reset; the value is loaded on the first edge.
    task automatic test_scan(input logic [15:0] val);
        logic [13:0] sexp [$];
        logic [13:0] e, g;
        int          slot;
        logic [3:0]  nib;
        logic        blank;
        logic [15:0] upper;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            slot = ((k - 1) / 4) % 4;
            nib  = (k == 1) ? 4'd0 : val[slot*4 +: 4];
            upper = (k == 1) ? 16'h0000 : (val >> (slot * 4));
            blank = 1'b0;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
            blank = (slot > 0) && (upper == 16'h0000);
`endif
            sexp.push_back({4'b0001 << slot, blank ? 10'b0 : (10'b1 << nib)});
            if (k == 1) begin
                load = 1'b1;
                load_data = val;
            end
            tick();
            load = 1'b0;
            e = sexp.pop_front();
            g = {dig_sel, dec_out};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL scan_%h cyc=%0d sel/dec got=%b/%b exp=%b/%b", val, k, g[13:10], g[9:0], e[13:10], e[9:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_ripple();
        test_wrap();
        test_invalid_load();
        test_priority();
        test_back_to_back();
        test_scan(16'h4321);
        test_scan(16'h0005);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
